shift_deserializer: RTL

// Serial-in / parallel-out collector: the receiving end of the serial stream

---
 rtl/shift_deserializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in/parallel-out collector with one-word valid/ready output buffer.
// Optional trailing even-parity bit when DESER_PARITY_EN is defined.
module shift_deserializer #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     flush_n,
  input  logic                     sin,
  input  logic                     sin_vld,
  input  logic                     dir,
  output logic [N-1:0]             par_out,
  output logic                     par_vld,
  input  logic                     par_rdy,
  output logic                     busy,
  output logic [$clog2(N+1)-1:0]   bit_cnt,
  output logic                     ovf,
  output logic                     par_err
);
  localparam int CW = $clog2(N+1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_shreg;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic [N-1:0]  r_par_out;
  logic          r_vld;
  logic          r_ovf;
  logic          r_err;

  logic          w_dir;
  logic [N-1:0]  w_shift;
  logic          w_last_data;
  logic          w_done;
  logic [N-1:0]  w_word;
  logic          w_err;
  logic [1:0]    w_state_nx;

  // shift order is latched on the first bit so mid-word dir changes are ignored
  assign w_dir       = (r_state == S_IDLE) ? dir : r_dir;
  assign w_shift     = w_dir ? {sin, r_shreg[N-1:1]} : {r_shreg[N-2:0], sin};
  assign w_last_data = sin_vld && (r_cnt == CW'(N-1));

`ifdef DESER_PARITY_EN
  assign w_done = sin_vld && (r_state == S_PARITY);
  assign w_word = r_shreg;
  assign w_err  = ^r_shreg ^ sin;
`else
  assign w_done = w_last_data;
  assign w_word = w_shift;
  assign w_err  = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    if (r_state == S_IDLE)
      w_state_nx = sin_vld ? S_SHIFT : S_IDLE;
    else if (r_state == S_SHIFT)
`ifdef DESER_PARITY_EN
      w_state_nx = w_last_data ? S_PARITY : S_SHIFT;
`else
      w_state_nx = w_last_data ? S_IDLE : S_SHIFT;
`endif
    else if (r_state == S_PARITY)
      w_state_nx = sin_vld ? S_IDLE : S_PARITY;
    else
      w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else if (!flush_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (sin_vld && r_state == S_IDLE)
        r_dir <= dir;
      if (sin_vld && r_state != S_PARITY)
        r_shreg <= w_shift;
      if (w_done)
        r_cnt <= '0;
      else if (sin_vld)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // a completed word loads only if the buffer is empty or drained on this same edge
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_par_out <= '0;
      r_vld     <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else if (!flush_n) begin
      r_par_out <= '0;
      r_vld     <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_done && (!r_vld || par_rdy)) begin
      r_par_out <= w_word;
      r_vld     <= 1'b1;
      r_err     <= w_err;
    end else if (w_done) begin
      r_ovf <= 1'b1;
    end else if (r_vld && par_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign par_out = r_par_out;
  assign par_vld = r_vld;
  assign ovf     = r_ovf;
  assign par_err = r_err;
  assign bit_cnt = r_cnt;
  assign busy    = (r_cnt != '0);
endmodule
